// File: rtl/umi_iso_pkg.sv
// Shared types and constants for the UMI isolation sequencing front-end.
package umi_iso_pkg;

   // Width of the wake settle counter.
   localparam int ISO_CNT_W = 8;

   // Isolation sequencer states.
   typedef enum logic [1:0] {
      ON    = 2'd0,
      DRAIN = 2'd1,
      ISO   = 2'd2,
      WAKE  = 2'd3
   } umi_iso_state_t;

endpackage

// File: rtl/umi_iso_slice.sv
// One-entry registered UMI valid/ready slice.
// accept_en gates new beats from outside.
// empty_next reports that the slice will hold no beat after this edge.
module umi_iso_slice
   import umi_iso_pkg::*;
#(
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 256
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          accept_en,
   input  logic          in_valid,
   input  logic [CW-1:0] in_cmd,
   input  logic [AW-1:0] in_dstaddr,
   input  logic [AW-1:0] in_srcaddr,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [CW-1:0] out_cmd,
   output logic [AW-1:0] out_dstaddr,
   output logic [AW-1:0] out_srcaddr,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic          empty_next
);

   logic          valid_q, valid_d;
   logic [CW-1:0] cmd_q, cmd_d;
   logic [AW-1:0] dst_q, dst_d;
   logic [AW-1:0] src_q, src_d;
   logic [DW-1:0] data_q, data_d;
   logic          in_ready_s;
   logic          accept_s;

   // Handshake decode and next-state of the valid flag and payload.
   always_comb begin
      in_ready_s = accept_en & (~valid_q | out_ready);
      accept_s   = in_valid & in_ready_s;
      valid_d    = valid_q;
      cmd_d      = cmd_q;
      dst_d      = dst_q;
      src_d      = src_q;
      data_d     = data_q;
      if (accept_s) begin
         valid_d = 1'b1;
         cmd_d   = in_cmd;
         dst_d   = in_dstaddr;
         src_d   = in_srcaddr;
         data_d  = in_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      empty_next = ~accept_s & (~valid_q | out_ready);
   end

   // Slice storage; a reset discards any buffered beat.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= 1'b0;
         cmd_q   <= '0;
         dst_q   <= '0;
         src_q   <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         cmd_q   <= cmd_d;
         dst_q   <= dst_d;
         src_q   <= src_d;
         data_q  <= data_d;
      end
   end

   assign in_ready    = in_ready_s;
   assign out_valid   = valid_q;
   assign out_cmd     = cmd_q;
   assign out_dstaddr = dst_q;
   assign out_srcaddr = src_q;
   assign out_data    = data_q;

endmodule

// File: rtl/umi_iso_ctrl.sv
// Isolation sequencing front-end for a switchable power domain.
// Drains the slice before asserting isolate and holds the path closed
// for a settle time after release.
module umi_iso_ctrl
   import umi_iso_pkg::*;
#(
   parameter int CW     = 32,
   parameter int AW     = 64,
   parameter int DW     = 256,
   parameter int SETTLE = 4
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          iso_req,
   output logic          iso_ack,
   output logic          isolate,
   input  logic          umi_in_valid,
   input  logic [CW-1:0] umi_in_cmd,
   input  logic [AW-1:0] umi_in_dstaddr,
   input  logic [AW-1:0] umi_in_srcaddr,
   input  logic [DW-1:0] umi_in_data,
   output logic          umi_in_ready,
   output logic          umi_out_valid,
   output logic [CW-1:0] umi_out_cmd,
   output logic [AW-1:0] umi_out_dstaddr,
   output logic [AW-1:0] umi_out_srcaddr,
   output logic [DW-1:0] umi_out_data,
   input  logic          umi_out_ready
);

   localparam logic [ISO_CNT_W-1:0] SETTLE_LD = ISO_CNT_W'(SETTLE - 1);

   umi_iso_state_t       state_q, state_d;
   logic [ISO_CNT_W-1:0] cnt_q, cnt_d;
   logic                 isolate_q, isolate_d;
   logic                 ack_q, ack_d;
   logic                 accept_en_s;
   logic                 empty_next_s;

   // Beats are only taken while fully on and no isolation is being asked for;
   // the request gates ready in the same cycle it appears.
   always_comb begin
      accept_en_s = (state_q == ON) & ~iso_req;
   end

   umi_iso_slice #(
      .CW (CW),
      .AW (AW),
      .DW (DW)
   ) u_slice (
      .clk         (clk),
      .nreset      (nreset),
      .accept_en   (accept_en_s),
      .in_valid    (umi_in_valid),
      .in_cmd      (umi_in_cmd),
      .in_dstaddr  (umi_in_dstaddr),
      .in_srcaddr  (umi_in_srcaddr),
      .in_data     (umi_in_data),
      .in_ready    (umi_in_ready),
      .out_valid   (umi_out_valid),
      .out_cmd     (umi_out_cmd),
      .out_dstaddr (umi_out_dstaddr),
      .out_srcaddr (umi_out_srcaddr),
      .out_data    (umi_out_data),
      .out_ready   (umi_out_ready),
      .empty_next  (empty_next_s)
   );

   // Sequencer next state, settle counter and registered-output decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ON: begin
            if (iso_req) begin
               state_d = DRAIN;
            end else begin
               state_d = ON;
            end
         end
         DRAIN: begin
            // A late release of iso_req is ignored until ISO is reached.
            if (empty_next_s) begin
               state_d = ISO;
            end else begin
               state_d = DRAIN;
            end
         end
         ISO: begin
            if (!iso_req) begin
               state_d = WAKE;
               cnt_d   = SETTLE_LD;
            end else begin
               state_d = ISO;
            end
         end
         WAKE: begin
            // Counter never wraps: it stops at zero when leaving WAKE.
            if (cnt_q == {ISO_CNT_W{1'b0}}) begin
               state_d = ON;
            end else begin
               cnt_d   = cnt_q - {{(ISO_CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ON;
            cnt_d   = {ISO_CNT_W{1'b0}};
         end
      endcase
      isolate_d = (state_d == ISO);
      ack_d     = (state_d == ISO) | (state_d == WAKE);
   end

   // Sequencer state, counter and handshake output registers.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= ON;
         cnt_q     <= {ISO_CNT_W{1'b0}};
         isolate_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isolate_q <= isolate_d;
         ack_q     <= ack_d;
      end
   end

   assign isolate = isolate_q;
   assign iso_ack = ack_q;

endmodule

// File: tb/tb_umi_iso_ctrl.sv
// Directed self-checking bench for umi_iso_ctrl (default parameters, SETTLE=4).
module tb_umi_iso_ctrl;

   logic          clk;
   logic          nreset;
   logic          iso_req;
   logic          iso_ack;
   logic          isolate;
   logic          in_valid;
   logic [31:0]   in_cmd;
   logic [63:0]   in_dst;
   logic [63:0]   in_src;
   logic [255:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [31:0]   out_cmd;
   logic [63:0]   out_dst;
   logic [63:0]   out_src;
   logic [255:0]  out_data;
   logic          out_ready;

   int checks;
   int errors;

   umi_iso_ctrl dut (
      .clk             (clk),
      .nreset          (nreset),
      .iso_req         (iso_req),
      .iso_ack         (iso_ack),
      .isolate         (isolate),
      .umi_in_valid    (in_valid),
      .umi_in_cmd      (in_cmd),
      .umi_in_dstaddr  (in_dst),
      .umi_in_srcaddr  (in_src),
      .umi_in_data     (in_data),
      .umi_in_ready    (in_ready),
      .umi_out_valid   (out_valid),
      .umi_out_cmd     (out_cmd),
      .umi_out_dstaddr (out_dst),
      .umi_out_srcaddr (out_src),
      .umi_out_data    (out_data),
      .umi_out_ready   (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [255:0] data_of(input logic [63:0] a);
      return {a, ~a, a ^ 64'h5A5A_5A5A_5A5A_5A5A, a + 64'd7};
   endfunction

   function automatic logic [31:0] cmd_of(input logic [63:0] a);
      return a[31:0] ^ 32'hA5A5_0000;
   endfunction

   task automatic set_beat(input logic v, input logic [63:0] a);
      in_valid = v;
      in_dst   = a;
      in_src   = ~a;
      in_cmd   = cmd_of(a);
      in_data  = data_of(a);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      nreset = 1'b0; iso_req = 1'b0; out_ready = 1'b1;
      set_beat(1'b0, 64'd0);
      #12;
      checks++;
      if (out_valid !== 1'b0 || isolate !== 1'b0 || iso_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b isolate=%b ack=%b, expected 0 0 0", out_valid, isolate, iso_ack);
      end
      checks++;
      if (out_dst !== 64'd0 || out_data !== 256'd0 || out_cmd !== 32'd0 || out_src !== 64'd0) begin
         errors++;
         $display("FAIL reset_payload: got dst=%h cmd=%h, expected all zero", out_dst, out_cmd);
      end
      nreset = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_passthrough();
      logic [63:0] a;
      out_ready = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         if (i > 0) begin
            a = 64'h1000 + 64'(i - 1);
            checks++;
            if (out_valid !== 1'b1 || out_dst !== a || out_src !== ~a || out_cmd !== cmd_of(a) || out_data !== data_of(a)) begin
               errors++;
               $display("FAIL pass_beat%0d: got valid=%b dst=%h, expected 1 %h", i - 1, out_valid, out_dst, a);
            end
         end
         if (i < 16) begin
            set_beat(1'b1, 64'h1000 + 64'(i));
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL pass_ready%0d: got %b expected 1", i, in_ready);
            end
         end else begin
            set_beat(1'b0, 64'd0);
         end
         step();
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pass_idle: got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      set_beat(1'b1, 64'h2000);
      step();
      set_beat(1'b1, 64'h2001);
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_dst !== 64'h2000 || out_data !== data_of(64'h2000)) begin
            errors++;
            $display("FAIL bp_hold%0d: got ready=%b valid=%b dst=%h, expected 0 1 2000", k, in_ready, out_valid, out_dst);
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 1", in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_dst !== 64'h2001 || out_data !== data_of(64'h2001)) begin
         errors++;
         $display("FAIL bp_next_beat: got valid=%b dst=%h, expected 1 2001", out_valid, out_dst);
      end
      set_beat(1'b0, 64'd0);
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_dup: got valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_drain_stall();
      out_ready = 1'b0;
      set_beat(1'b1, 64'h3000);
      step();
      iso_req = 1'b1;
      set_beat(1'b1, 64'h3001);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL drain_gate: got ready=%b expected 0", in_ready);
      end
      step();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (isolate !== 1'b0 || iso_ack !== 1'b0 || out_valid !== 1'b1 || out_dst !== 64'h3000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_hold%0d: got iso=%b ack=%b valid=%b dst=%h rdy=%b, expected 0 0 1 3000 0",
                     k, isolate, iso_ack, out_valid, out_dst, in_ready);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (isolate !== 1'b1 || iso_ack !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_exit: got iso=%b ack=%b valid=%b, expected 1 1 0", isolate, iso_ack, out_valid);
      end
      iso_req = 1'b0;
      set_beat(1'b0, 64'd0);
      repeat (5) step();
      checks++;
      if (iso_ack !== 1'b0 || isolate !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_wake_done: got ack=%b iso=%b valid=%b, expected 0 0 0", iso_ack, isolate, out_valid);
      end
   endtask

   task automatic test_iso_wake();
      out_ready = 1'b1;
      iso_req = 1'b1;
      set_beat(1'b1, 64'h4000);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL iso_gate_n: got ready=%b expected 0", in_ready);
      end
      step();
      checks++;
      if (isolate !== 1'b0 || iso_ack !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL iso_n1: got iso=%b ack=%b valid=%b, expected 0 0 0", isolate, iso_ack, out_valid);
      end
      step();
      checks++;
      if (isolate !== 1'b1 || iso_ack !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL iso_n2: got iso=%b ack=%b valid=%b, expected 1 1 0", isolate, iso_ack, out_valid);
      end
      iso_req = 1'b0;
      step();
      checks++;
      if (isolate !== 1'b0 || iso_ack !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL wake_m1: got iso=%b ack=%b rdy=%b, expected 0 1 0", isolate, iso_ack, in_ready);
      end
      for (int k = 2; k <= 4; k++) begin
         step();
         checks++;
         if (iso_ack !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_m%0d: got ack=%b rdy=%b valid=%b, expected 1 0 0", k, iso_ack, in_ready, out_valid);
         end
      end
      step();
      checks++;
      if (iso_ack !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL wake_m5: got ack=%b rdy=%b, expected 0 1", iso_ack, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_dst !== 64'h4000 || out_data !== data_of(64'h4000)) begin
         errors++;
         $display("FAIL wake_accept: got valid=%b dst=%h, expected 1 4000", out_valid, out_dst);
      end
      set_beat(1'b0, 64'd0);
      step();
   endtask

   task automatic test_reassert_in_wake();
      out_ready = 1'b1;
      iso_req = 1'b1;
      step();
      step();
      iso_req = 1'b0;
      step();
      step();
      step();
      iso_req = 1'b1;
      set_beat(1'b1, 64'h5000);
      step();
      checks++;
      if (iso_ack !== 1'b1 || isolate !== 1'b0) begin
         errors++;
         $display("FAIL reas_m4: got ack=%b iso=%b, expected 1 0", iso_ack, isolate);
      end
      step();
      checks++;
      if (iso_ack !== 1'b0 || isolate !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reas_on: got ack=%b iso=%b rdy=%b, expected 0 0 0", iso_ack, isolate, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || isolate !== 1'b0) begin
         errors++;
         $display("FAIL reas_drain: got valid=%b iso=%b, expected 0 0", out_valid, isolate);
      end
      step();
      checks++;
      if (isolate !== 1'b1 || iso_ack !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reas_iso: got iso=%b ack=%b valid=%b, expected 1 1 0", isolate, iso_ack, out_valid);
      end
      iso_req = 1'b0;
      set_beat(1'b0, 64'd0);
      repeat (5) step();
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      set_beat(1'b1, 64'h6000);
      step();
      iso_req = 1'b1;
      set_beat(1'b0, 64'd0);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_dst !== 64'h6000) begin
         errors++;
         $display("FAIL arst_pre: got valid=%b dst=%h, expected 1 6000", out_valid, out_dst);
      end
      #2;
      nreset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || isolate !== 1'b0 || iso_ack !== 1'b0 || out_dst !== 64'd0) begin
         errors++;
         $display("FAIL arst_now: got valid=%b iso=%b ack=%b dst=%h, expected 0 0 0 0",
                  out_valid, isolate, iso_ack, out_dst);
      end
      iso_req = 1'b0;
      out_ready = 1'b1;
      #2;
      nreset = 1'b1;
      step();
      set_beat(1'b1, 64'h7000);
      #1;
      checks++;
      if (in_ready !== 1'b1 || iso_ack !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL arst_on: got rdy=%b ack=%b valid=%b, expected 1 0 0", in_ready, iso_ack, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_dst !== 64'h7000) begin
         errors++;
         $display("FAIL arst_beat: got valid=%b dst=%h, expected 1 7000", out_valid, out_dst);
      end
      set_beat(1'b0, 64'd0);
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_passthrough();
      test_backpressure();
      test_drain_stall();
      test_iso_wake();
      test_reassert_in_wake();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/umi_iso_ctrl.md
# umi_iso_ctrl

Isolation sequencing front-end for a switchable power domain. It sits directly upstream of `umi_isolate`. Traffic passes through a one-entry registered UMI slice. On an isolation request the block stops accepting new requests, drains the slice, asserts `isolate` to the downstream `umi_isolate`, and acknowledges. On release it deasserts `isolate`, waits a programmable settle time, then reopens the path.

## Interface
- `CW`, default 32: UMI command width.
- `AW`, default 64: UMI address width.
- `DW`, default 256: UMI data width.
- `SETTLE`, default 4: wake settle cycles, legal range 1..255.

Ports:
- `clk` — input, 1: single clock.
- `nreset` — input, 1: reset, asynchronous assert, active-low.
- `iso_req` — input, 1: isolation request, level, four-phase with `iso_ack`.
- `iso_ack` — output, 1: isolation complete or wake pending.
- `isolate` — output, 1: drives the `isolate` input of `umi_isolate`.
- `umi_in_valid` — input, 1: upstream valid.
- `umi_in_cmd` — input, CW: upstream command.
- `umi_in_dstaddr` — input, AW: upstream destination address.
- `umi_in_srcaddr` — input, AW: upstream source address.
- `umi_in_data` — input, DW: upstream data.
- `umi_in_ready` — output, 1: upstream ready.
- `umi_out_valid` — output, 1: to `umi_isolate` `umi_valid`.
- `umi_out_cmd`, `umi_out_dstaddr`, `umi_out_srcaddr`, `umi_out_data` — output, CW/AW/AW/DW: registered payload.
- `umi_out_ready` — input, 1: from `umi_isolate` `umi_ready`.

## Operation
- States: ON, DRAIN, ISO, WAKE. Reset state is ON.
- Slice behaviour:
  - Accept when `umi_in_valid & umi_in_ready`.
  - `umi_in_ready = (state==ON) & ~iso_req & (~umi_out_valid | umi_out_ready)`.
  - The payload register loads on accept only.
  - The payload is held stable while `umi_out_valid & ~umi_out_ready`.
  - `umi_out_valid` clears on a handshake with no accept in the same cycle.
- ON:
  - `iso_req=1` → DRAIN.
  - The beat offered in the cycle `iso_req` is first seen is not accepted. `umi_in_ready` is gated combinationally.
- DRAIN:
  - No accepts.
  - When the slice is empty next cycle, → ISO. The slice is empty next cycle if `~umi_out_valid`, or if `umi_out_valid & umi_out_ready`.
  - `iso_req` dropping in DRAIN: still complete to ISO. Deassertion is only honoured in ISO.
- ISO:
  - `isolate=1`, `iso_ack=1`, `umi_out_valid=0`.
  - `iso_req=0` → WAKE, with the settle counter loaded to `SETTLE-1`.
- WAKE:
  - `isolate=0`, `iso_ack=1`, no accepts.
  - The counter decrements each cycle. At 0 → ON.
- `iso_ack` drops on entry to ON, which completes the four-phase handshake.
- `iso_req` reasserted during WAKE: WAKE completes, then ON sees `iso_req` and goes to DRAIN next cycle. No beat is accepted in between.
- Settle counter: 8 bits, decrement only, no wrap. It saturates at 0.

## Timing
- Reset values: `umi_out_valid=0`, payload all zero, `isolate=0`, `iso_ack=0`, state ON, counter 0.
- Data latency: 1 cycle from in-handshake to `umi_out_valid`. Throughput is 1 beat/cycle under continuous `umi_out_ready`.
- `isolate` and `iso_ack` are registered. They rise 1 cycle after the DRAIN exit condition.
- With an empty slice and `iso_req` rising at cycle N:
  - DRAIN at N+1.
  - ISO at N+2.
  - `isolate=1` and `iso_ack=1` visible at N+2.
- `iso_req` falling at cycle M in ISO:
  - `isolate=0` at M+1.
  - `umi_in_ready` can rise at M+1+SETTLE.
  - `iso_ack=0` at M+1+SETTLE.
- A stalled slice (`umi_out_ready=0`) holds DRAIN indefinitely. `isolate` never asserts over a valid beat.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). Any buffered beat is discarded.

## Structure
- Package `umi_iso_pkg`: state enum `umi_iso_state_t` (ON=2'd0, DRAIN=2'd1, ISO=2'd2, WAKE=2'd3) and the counter width localparam `ISO_CNT_W=8`.
- Sub-module `umi_iso_slice`: the one-entry valid/ready register slice, with an external `accept_en` gate input and an `empty_next` output. The top level holds the FSM and the settle counter.

## Test plan
- Pass-through: 16 back-to-back beats with `umi_out_ready=1`, `dstaddr=0x1000+i`.
  - → Each beat appears exactly 1 cycle later, in order, with no bubbles.
- Backpressure: `umi_out_ready=0` for 5 cycles with a beat in the slice.
  - → Payload stable, `umi_in_ready=0`, no loss or duplication after release.
- Drain under stall: beat buffered, `umi_out_ready=0`, `iso_req` rises.
  - → Stays in DRAIN with `isolate=0`.
  - `umi_out_ready` rises at cycle K → `isolate=1` and `iso_ack=1` at K+1.
- Isolate timing, empty slice: `iso_req` rises at cycle N.
  - → `isolate=1` at N+2.
  - The beat offered at N is never accepted; it is accepted only after wake.
- Wake with `SETTLE=4`: `iso_req` falls at M.
  - → `isolate=0` at M+1, `iso_ack=0` and `umi_in_ready=1` at M+5.
  - Reassert `iso_req` at M+3 → ON for 1 cycle with no accept, then DRAIN.
- Async reset: assert `nreset=0` mid-DRAIN with a beat buffered.
  - → `umi_out_valid`, `isolate` and `iso_ack` are 0 immediately; state is ON after release.
